huff_bit_packer: RTL and testbench
==================================

Name: huff_bit_packer

Overview:
- Sits directly downstream of the Huffman encoder `main`.
- Takes the encoder's serial code bitstream (`data` qualified by `output_start`, terminated by `done`) and packs it into fixed-width words, MSB-first.
- Buffers the words in a small show-ahead FIFO and presents them on a valid/ready interface to the storage/transmit stage.
- Every word carries a valid-bit count; the final word of each stream carries a last flag.

Parameters:
- WORD_W, 8, packed word width in bits; must be 2 or more.
- DEPTH, 4, FIFO depth in words; must be a power of 2, 2 or more.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- bit_in  in  1  serial code bit from the encoder (`data`).
- bit_valid  in  1  bit_in is valid this cycle (encoder `output_start`).
- stream_done  in  1  one-cycle pulse: encoder stream finished (encoder `done`).
- word_out  out  WORD_W  packed word at the FIFO head.
- word_bits  out  clog2(WORD_W+1)  number of valid bits in word_out (0..WORD_W), left-justified.
- word_last  out  1  the head word is the final word of the stream.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word when word_valid && word_ready.
- busy  out  1  high when state != IDLE or the FIFO is not empty.
- overflow  out  1  sticky: a word was dropped, or a bit arrived in FLUSH.

Behaviour:
- Reset (asynchronous, nRST=0):
  - state=IDLE; shift register, fill count and FIFO pointers cleared.
  - word_valid=0, word_out=0, word_bits=0, word_last=0, busy=0, overflow=0.
  - Reset mid-stream discards all partial and buffered data.
- Packing:
  - Each cycle with bit_valid=1, sr <= {sr[WORD_W-2:0], bit_in} and cnt <= cnt+1.
  - The first bit received is the MSB of the word.
- Word complete (bit_valid with cnt==WORD_W-1):
  - Push entry {data={sr[WORD_W-2:0],bit_in}, bits=WORD_W, last=0}; cnt <= 0.
  - word_valid rises the cycle after the completing bit, so push-to-output latency is 1 cycle.
- States:
  - IDLE: bit_valid=1 -> COLLECT (the bit is absorbed). stream_done in IDLE -> FLUSH (produces an empty last entry).
  - COLLECT: absorbs bits. stream_done=1 -> FLUSH. If bit_valid coincides with stream_done, the bit is absorbed first, including any word push it causes.
  - FLUSH: pushes the tail entry {data=sr<<(WORD_W-cnt), zero-padded; bits=cnt; last=1}, then -> IDLE with cnt=0.
    - cnt==0 gives a tail entry of bits=0, last=1.
    - If the FIFO is full, stay in FLUSH until a slot frees; the push occurs in the same cycle as the pop.
    - bit_valid in FLUSH: the bit is ignored and overflow is set.
- FIFO:
  - Show-ahead; word_out, word_bits and word_last reflect the head entry. Pop on word_valid && word_ready.
  - Push when full is accepted only if a pop happens in the same cycle.
  - Otherwise a completed word (COLLECT) is dropped, overflow is set, and cnt still resets to 0.
  - Simultaneous push and pop when not full: occupancy is unchanged.
  - Pointers wrap modulo DEPTH; the occupancy counter is clog2(DEPTH)+1 bits.
  - When word_valid=0, word_out, word_bits and word_last hold their last values; consumers must qualify with word_valid.
- overflow clears only on reset.

Optional Feature:
- Macro: HUFF_PACK_LSB_FIRST_EN.
- Defined:
  - Bits pack LSB-first: sr <= {bit_in, sr[WORD_W-1:1]}.
  - Tail word is right-justified: data = sr>>(WORD_W-cnt), zero-padded at the top.
- Undefined: MSB-first, left-justified as specified above.
- Ports, handshake and latency are identical in both builds.

Test Plan:
- WORD_W=8; 16 bits 1,0,1,1,0,0,1,0, 1,1,1,1,0,0,0,0 with word_ready=1, then stream_done -> three entries:
  - 0xB2/bits=8/last=0;
  - 0xF0/bits=8/last=0;
  - 0x00/bits=0/last=1.
- 11 bits 1,1,0,1,0,0,0,1, 1,0,1 with stream_done coincident with the 11th bit -> two entries:
  - 0xD1/8/0;
  - 0xA0/3/1, word_valid rising 2 cycles after stream_done.
- word_ready=0, DEPTH=4, 40 continuous bits -> FIFO holds 4 words, the 5th is dropped, overflow=1 and stays high. Then word_ready=1 pops exactly 4 words in order and busy falls once the FIFO is drained and state=IDLE.
- FIFO full, stream_done with cnt=5 -> state stays FLUSH. Raising word_ready pops one word and the tail (bits=5, last=1) is pushed in the same cycle. overflow stays 0.
- nRST pulsed low mid-word (cnt=4) with 2 words buffered -> word_valid=0, busy=0, overflow=0 immediately. A following 8-bit stream emits only the new word.
- With HUFF_PACK_LSB_FIRST_EN defined, bits 1,0,1,1,0,0,1,0 -> 0x4D, bits=8.

Source files
------------

// File: rtl/huff_bit_packer.sv
// Packs the Huffman encoder's serial code bits into WORD_W-bit words and queues them in a show-ahead FIFO.
// Build option: define HUFF_PACK_LSB_FIRST_EN for LSB-first packing with right-justified tail words.
module huff_bit_packer #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  input  logic                         stream_done,
  output logic [WORD_W-1:0]            word_out,
  output logic [$clog2(WORD_W+1)-1:0]  word_bits,
  output logic                         word_last,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         busy,
  output logic                         overflow
);

  localparam int CW = $clog2(WORD_W);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH
  } state_e;

  state_e              state_q;
  logic [WORD_W-1:0]   sr_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;

  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         occ_q;
  logic [WORD_W-1:0]   mem_data [DEPTH];
  logic [BW-1:0]       mem_bits [DEPTH];
  logic                mem_last [DEPTH];

  logic [WORD_W-1:0]   out_data_q;
  logic [BW-1:0]       out_bits_q;
  logic                out_last_q;

  logic [WORD_W-1:0]   sr_shift;
  logic [WORD_W-1:0]   tail_data;
  logic [BW-1:0]       tail_shamt;
  logic                in_flush;
  logic                word_done;
  logic                pop, full, push_req, push;
  logic [WORD_W-1:0]   push_data;
  logic [BW-1:0]       push_bits;
  logic                push_last;
  logic [AW:0]         occ_d;
  logic [AW-1:0]       rd_d, wr_d;

  assign in_flush   = (state_q == FLUSH);
  assign tail_shamt = BW'(WORD_W) - BW'(cnt_q);

`ifdef HUFF_PACK_LSB_FIRST_EN
  assign sr_shift  = {bit_in, sr_q[WORD_W-1:1]};
  assign tail_data = sr_q >> tail_shamt;
`else
  assign sr_shift  = {sr_q[WORD_W-2:0], bit_in};
  assign tail_data = sr_q << tail_shamt;
`endif

  assign word_done = bit_valid && !in_flush && (cnt_q == CW'(WORD_W - 1));
  assign pop       = (occ_q != '0) && word_ready;
  assign full      = (occ_q == (AW+1)'(DEPTH));
  assign push_req  = word_done || in_flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);

  always_comb begin
    push_data = sr_shift;
    push_bits = BW'(WORD_W);
    push_last = 1'b0;
    if (in_flush) begin
      push_data = tail_data;
      push_bits = BW'(cnt_q);
      push_last = 1'b1;
    end
  end

  assign occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_d  = rd_q + AW'(pop);
  assign wr_d  = wr_q + AW'(push);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (bit_valid) begin
            sr_q    <= sr_shift;
            cnt_q   <= word_done ? '0 : cnt_q + CW'(1);
            state_q <= COLLECT;
            if (word_done && !push) ovf_q <= 1'b1;
          end
          if (stream_done) state_q <= FLUSH;
        end
        FLUSH: begin
          if (bit_valid) ovf_q <= 1'b1;
          if (push) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wr_q] <= push_data;
      mem_bits[wr_q] <= push_bits;
      mem_last[wr_q] <= push_last;
    end
  end

  // Head outputs are registered from the post-edge head; a push into an otherwise empty FIFO bypasses the array.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      out_data_q <= '0;
      out_bits_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      if (occ_d != '0) begin
        if (occ_q == (AW+1)'(pop)) begin
          out_data_q <= push_data;
          out_bits_q <= push_bits;
          out_last_q <= push_last;
        end else begin
          out_data_q <= mem_data[rd_d];
          out_bits_q <= mem_bits[rd_d];
          out_last_q <= mem_last[rd_d];
        end
      end
    end
  end

  assign word_out   = out_data_q;
  assign word_bits  = out_bits_q;
  assign word_last  = out_last_q;
  assign word_valid = (occ_q != '0);
  assign busy       = (state_q != IDLE) || (occ_q != '0);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_huff_bit_packer.sv
// Randomized and directed bench for huff_bit_packer against a queue-based reference model.
module tb_huff_bit_packer;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int BW = $clog2(W + 1);

  logic          CLK = 1'b0;
  logic          nRST;
  logic          bit_in, bit_valid, stream_done, word_ready;
  logic [W-1:0]  word_out;
  logic [BW-1:0] word_bits;
  logic          word_last, word_valid, busy, overflow;

  huff_bit_packer #(.WORD_W(W), .DEPTH(D)) dut (
    .CLK(CLK), .nRST(nRST), .bit_in(bit_in), .bit_valid(bit_valid),
    .stream_done(stream_done), .word_out(word_out), .word_bits(word_bits),
    .word_last(word_last), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] data;
    int           bits;
    bit           last;
  } ent_t;

  ent_t mq[$];
  bit   mbits[$];
  bit   m_active, m_flush, m_ovf;
  ent_t plog[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic ent_t pack_bits(input bit last);
    ent_t e;
    e.data = '0;
    for (int i = 0; i < mbits.size(); i++) begin
`ifdef HUFF_PACK_LSB_FIRST_EN
      e.data[i] = mbits[i];
`else
      e.data[W-1-i] = mbits[i];
`endif
    end
    e.bits = mbits.size();
    e.last = last;
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    mbits.delete();
    m_active = 0;
    m_flush  = 0;
    m_ovf    = 0;
  endtask

  task automatic model_edge(input bit bv, input bit bi, input bit sd, input bit rdy);
    bit can_push;
    can_push = (mq.size() < D) || (mq.size() != 0 && rdy);
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (m_flush) begin
      if (bv) m_ovf = 1;
      if (can_push) begin
        mq.push_back(pack_bits(1'b1));
        mbits.delete();
        m_flush = 0;
      end
    end else begin
      if (bv) begin
        mbits.push_back(bi);
        m_active = 1;
        if (mbits.size() == W) begin
          if (can_push) mq.push_back(pack_bits(1'b0));
          else m_ovf = 1;
          mbits.delete();
        end
      end
      if (sd) begin
        m_flush  = 1;
        m_active = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("word_valid", 32'(word_valid), 32'(mq.size() != 0));
    check("busy", 32'(busy), 32'(m_active || m_flush || mq.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      check("word_out", 32'(word_out), 32'(mq[0].data));
      check("word_bits", 32'(word_bits), 32'(mq[0].bits));
      check("word_last", 32'(word_last), 32'(mq[0].last));
    end
  endtask

  task automatic cycle(input bit bv, input bit bi, input bit sd, input bit rdy);
    ent_t e;
    bit_valid   = bv;
    bit_in      = bi;
    stream_done = sd;
    word_ready  = rdy;
    @(negedge CLK);
    compare_outputs();
    if (word_valid && rdy) begin
      e.data = word_out;
      e.bits = int'(word_bits);
      e.last = word_last;
      plog.push_back(e);
    end
    model_edge(bv, bi, sd, rdy);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST        = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    stream_done = 1'b0;
    word_ready  = 1'b0;
    #1;
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_word", 32'(word_out), 32'd0);
    model_reset();
    plog.delete();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic send_bits(input logic [63:0] pat, input int n, input bit sd_last, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, pat[n-1-i], sd_last && (i == n - 1), rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic check_log(input int idx, input logic [W-1:0] d, input int b, input bit l);
    if (plog.size() > idx) begin
      check("log_data", 32'(plog[idx].data), 32'(d));
      check("log_bits", 32'(plog[idx].bits), 32'(b));
      check("log_last", 32'(plog[idx].last), 32'(l));
    end else begin
      check("log_missing", 32'(plog.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    @(posedge CLK);
    #1;
    do_reset();

`ifdef HUFF_PACK_LSB_FIRST_EN
    send_bits(64'b10110010, 8, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    check_log(0, 8'h4D, 8, 1'b0);
    check_log(1, 8'h00, 0, 1'b1);
`else
    send_bits(64'b10110010_11110000, 16, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("t1_count", 32'(plog.size()), 32'd3);
    check_log(0, 8'hB2, 8, 1'b0);
    check_log(1, 8'hF0, 8, 1'b0);
    check_log(2, 8'h00, 0, 1'b1);

    plog.delete();
    send_bits(64'b11010001_101, 11, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("t2_count", 32'(plog.size()), 32'd2);
    check_log(0, 8'hD1, 8, 1'b0);
    check_log(1, 8'hA0, 3, 1'b1);
`endif

    // 40 bits with no consumer: one word lost
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
    check("t3_ovf", 32'(overflow), 32'd1);
    idle(6, 1'b1);
    check("t3_pops", 32'(plog.size()), 32'd4);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("t3_busy", 32'(busy), 32'd0);

    // flush stalled by a full FIFO
    do_reset();
    for (int i = 0; i < 37; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);
    check("t4_ovf", 32'(overflow), 32'd0);
    check_log(4, plog.size() > 4 ? plog[4].data : '0, 5, 1'b1);

    // reset mid-word with two words buffered
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
    do_reset();
    send_bits(64'h5A, 8, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("t5_count", 32'(plog.size()), 32'd2);

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'(($urandom % 4) != 0), 1'($urandom), 1'(($urandom % 12) == 0),
            (i % 200 < 100) ? 1'(($urandom % 3) != 0) : 1'(($urandom % 5) == 0));
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(20, 1'b1);
    check("end_valid", 32'(word_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
